// File: rtl/stall_flush_ctrl.sv
// stall_flush_ctrl: pipeline stall/flush arbitration (memory wait, branch, load-use) with wait timeout.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_count performance counters. Rev 1.0
`default_nettype none

module stall_flush_ctrl #(
  parameter int MAX_MEM_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rdE,
  input  logic       mem_readE,
  input  logic       branch_takenE,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       pipe_freeze,
`ifdef HAZARD_PERF_CNT_EN
  output logic       mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`else
  output logic       mem_timeout
`endif
);

  localparam int CW = $clog2(MAX_MEM_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            timeout_q;
  logic            timeout_set;
  logic            freeze;
  logic            load_use;
  logic            mem_wait;

  assign load_use = mem_readE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign mem_wait = mem_req && !mem_ready;

  // Next-state: the freeze decision depends only on state and memory handshake.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    freeze      = 1'b0;
    timeout_set = 1'b0;
    case (state)
      RUN: begin
        if (mem_wait) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
          cnt_next   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          freeze = 1'b1;
          if (cnt == CW'(MAX_MEM_WAIT)) begin
            timeout_set = 1'b1;
            state_next  = RELEASE;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RELEASE: begin
        // Forced unfrozen cycle after a timeout so the pipeline can drain.
        state_next = RUN;
        cnt_next   = '0;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Output priority: reset, freeze, branch, load-use, normal.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_takenE) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_timeout = timeout_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      timeout_q <= timeout_q || timeout_set;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_write)
        stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 Parameter MAX_MEM_WAIT, default 16: consecutive data-memory wait cycles before timeout abort; legal range 2..255.
REQ-002 Port clk  input  1: single clock, all state on rising edge.
REQ-003 Port rst  input  1: reset, synchronous and active-high.
REQ-004 Port rs1D  input  5: ID-stage source register 1.
REQ-005 Port rs2D  input  5: ID-stage source register 2.
REQ-006 Port rdE  input  5: EX-stage destination register.
REQ-007 Port mem_readE  input  1: EX-stage instruction is a load.
REQ-008 Port branch_takenE  input  1: EX-stage branch or jump redirects the PC.
REQ-009 Port mem_req  input  1: MEM-stage data-memory access active.
REQ-010 Port mem_ready  input  1: data memory completes the access this cycle.
REQ-011 Port pc_write  output  1: 1 = PC updates, 0 = PC holds.
REQ-012 Port if_id_write  output  1: IF/ID write enable, 1 = update, 0 = stall.
REQ-013 Port if_id_flush  output  1: IF/ID loads a NOP (all zeros).
REQ-014 Port id_ex_flush  output  1: ID/EX loads a bubble (all control bits zero).
REQ-015 Port pipe_freeze  output  1: holds ID/EX, EX/MEM and MEM/WB.
REQ-016 Port mem_timeout  output  1: sticky flag, set when an access is aborted by timeout.

Function
REQ-017 The block SHALL use states RUN, MEM_WAIT and RELEASE, with a wait counter of width ceil(log2(MAX_MEM_WAIT+1)).
REQ-018 Control outputs SHALL be combinational from the current state and inputs, so a hazard is acted on in the cycle it is presented.
REQ-019 Load-use SHALL be true when mem_readE=1, rdE!=0, and rdE equals rs1D or rs2D.
REQ-020 Memory wait SHALL be true when mem_req=1 and mem_ready=0.
REQ-021 Priority, highest first: memory wait or MEM_WAIT state, then branch_takenE, then load-use, then normal.
REQ-022 Normal operation SHALL drive pc_write=1, if_id_write=1, and all of if_id_flush, id_ex_flush and pipe_freeze at 0.
REQ-023 Freeze SHALL drive pipe_freeze=1, pc_write=0 and if_id_write=0, with both flushes at 0.
REQ-024 Branch SHALL drive pc_write=1, if_id_write=1, if_id_flush=1 and id_ex_flush=1.
REQ-025 Load-use SHALL drive pc_write=0, if_id_write=0 and id_ex_flush=1 for exactly one cycle; it clears naturally once the bubble reaches EX.
REQ-026 A branch that coincides with load-use SHALL win, because the dependent instruction is being flushed.
REQ-027 RUN to MEM_WAIT: memory wait is true in RUN; freeze applies in that same cycle and the counter loads 1.
REQ-028 MEM_WAIT behaviour: freeze applies while mem_ready=0 and the counter increments each cycle.
REQ-029 MEM_WAIT with mem_ready=1: freeze is released in that same cycle, the next state is RUN and the counter clears.
REQ-030 MEM_WAIT timeout: when the counter equals MAX_MEM_WAIT and mem_ready=0, mem_timeout is set to 1 and the next state is RELEASE.
REQ-031 RELEASE SHALL last one cycle and ignore mem_req and mem_ready, producing no freeze; branch and load-use rules still apply; the next state is RUN.
REQ-032 A branch_takenE held during a freeze SHALL be acted on only in the first unfrozen cycle.
REQ-033 mem_timeout SHALL clear only on rst.

Reset
REQ-034 While rst=1, outputs SHALL be pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_freeze=0 and mem_timeout=0.
REQ-035 At the first clock edge with rst=1, the state SHALL become RUN and the counter 0, from any state including mid-MEM_WAIT.
REQ-036 The first cycle after rst deasserts SHALL follow the RUN rules.

Configuration
REQ-037 With HAZARD_PERF_CNT_EN defined, the block SHALL add output stall_cycles (32 bits), counting cycles with pc_write=0 excluding reset.
REQ-038 With HAZARD_PERF_CNT_EN defined, the block SHALL add output flush_count (32 bits), counting cycles with if_id_flush=1 excluding reset.
REQ-039 Both counters SHALL reset to 0 and wrap modulo 2^32.
REQ-040 Without HAZARD_PERF_CNT_EN, the counter ports and logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-041 Load-use: mem_readE=1, rdE=5, rs1D=5 -> for one cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (mem_readE=0) normal.
REQ-042 x0 case: mem_readE=1, rdE=0, rs2D=0 -> no stall; pc_write=1 and id_ex_flush=0.
REQ-043 Branch plus load-use: branch_takenE=1 with load-use on rdE=7 -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
REQ-044 Memory wait: mem_req=1 with mem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 for exactly 3 cycles and 0 in the ready cycle; state returns to RUN.
REQ-045 Timeout: MAX_MEM_WAIT=4, mem_ready held 0 -> mem_timeout=1 after the 4th wait cycle, one RELEASE cycle with pipe_freeze=0, flag holds until rst.
REQ-046 Reset mid-wait, with HAZARD_PERF_CNT_EN: rst during MEM_WAIT -> state RUN and the REQ-034 outputs; afterwards 2 load-use stalls and 1 branch give stall_cycles=2 and flush_count=1.
